// File: rtl/lcd_pkg.sv
// Shared constants, state types and address helper for the LCD text buffer.
package lcd_pkg;

  localparam int LINES      = 4;
  localparam int LINE_WIDTH = 20;
  localparam int DEPTH      = LINES * LINE_WIDTH;

  localparam logic [7:0] FILL_CHAR  = 8'h20;
  localparam logic [7:0] PRINT_MIN  = 8'h20;

  localparam logic [7:0] LCD_BS = 8'h08;
  localparam logic [7:0] LCD_LF = 8'h0A;
  localparam logic [7:0] LCD_FF = 8'h0C;
  localparam logic [7:0] LCD_CR = 8'h0D;

  localparam logic [6:0] LAST_IDX = 7'(DEPTH - 1);
  localparam logic [4:0] LAST_COL = 5'(LINE_WIDTH - 1);

  typedef enum logic {
    W_CLEAR,
    W_IDLE
  } wr_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_PULSE,
    T_WAIT
  } trg_state_e;

  // Linear store index of a (line, column) pair; valid for col < LINE_WIDTH.
  function automatic logic [6:0] char_addr(input logic [1:0] line, input logic [4:0] col);
    return 7'(line) * 7'(LINE_WIDTH) + 7'(col);
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// 80x8 character store: one synchronous write port, one registered read port.
module lcd_char_ram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_d;
  logic [7:0] rdata_q;

  // Write port.
  // NOTE: the array has no reset so it maps onto RAM; the CLEAR pass initialises it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read the array combinationally; the register below makes it read-before-write.
  always_comb begin
    rdata_d = mem[raddr];
  end

  // Output register of the read port.
  // NOTE: non-blocking here so a same-cycle write to raddr still returns the old byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lcd_text_buffer.sv
// Character frame buffer with cursor, control codes and driver refresh trigger.
module lcd_text_buffer
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       lcd_busy,
  output logic       lcd_trg,
  output logic [1:0] cur_line,
  output logic [4:0] cur_col
);

  wr_state_e  wr_state_q, wr_state_d;
  trg_state_e trg_state_q, trg_state_d;
  logic [6:0] clr_idx_q, clr_idx_d;
  logic [1:0] line_q, line_d;
  logic [4:0] col_q, col_d;
  logic       dirty_q, dirty_d;
  logic       wait_done_q, wait_done_d;
  logic       lcd_trg_q, lcd_trg_d;
  logic       rd_oor_q, rd_oor_d;

  logic       set_dirty;
  logic       fire;
  logic       ram_we;
  logic [6:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [6:0] ram_raddr;
  logic [7:0] ram_rdata;

  // Write FSM: clear sweep, byte acceptance, cursor movement.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    wr_state_d = wr_state_q;
    clr_idx_d  = clr_idx_q;
    line_d     = line_q;
    col_d      = col_q;
    ram_we     = 1'b0;
    ram_waddr  = clr_idx_q;
    ram_wdata  = FILL_CHAR;
    set_dirty  = 1'b0;

    case (wr_state_q)
      W_CLEAR: begin
        ram_we = 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          wr_state_d = W_IDLE;
          clr_idx_d  = '0;
          set_dirty  = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + 7'd1;
        end
      end
      W_IDLE: begin
        if (in_valid) begin
          if (in_data >= PRINT_MIN) begin
            ram_we    = 1'b1;
            ram_waddr = char_addr(line_q, col_q);
            ram_wdata = in_data;
            set_dirty = 1'b1;
            if (col_q == LAST_COL) begin
              col_d  = '0;
              line_d = line_q + 2'd1;
            end else begin
              col_d = col_q + 5'd1;
            end
          end else begin
            case (in_data)
              LCD_LF: begin
                line_d = line_q + 2'd1;
                col_d  = '0;
              end
              LCD_CR: col_d = '0;
              LCD_BS: if (col_q != '0) col_d = col_q - 5'd1;
              LCD_FF: begin
                wr_state_d = W_CLEAR;
                clr_idx_d  = '0;
                line_d     = '0;
                col_d      = '0;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // Trigger FSM: one pulse per dirty snapshot, then hold off until the driver settles.
  always_comb begin
    trg_state_d = trg_state_q;
    wait_done_d = wait_done_q;
    lcd_trg_d   = 1'b0;
    fire        = 1'b0;

    case (trg_state_q)
      T_IDLE: begin
        if (dirty_q && !lcd_busy && (wr_state_q == W_IDLE)) begin
          fire        = 1'b1;
          lcd_trg_d   = 1'b1;
          trg_state_d = T_PULSE;
        end
      end
      T_PULSE: begin
        trg_state_d = T_WAIT;
        wait_done_d = 1'b0;
      end
      T_WAIT: begin
        // The driver may take a cycle to raise busy, so ignore it for two cycles.
        wait_done_d = 1'b1;
        if (wait_done_q && !lcd_busy) trg_state_d = T_IDLE;
      end
      default: trg_state_d = T_IDLE;
    endcase

    // A write on the firing edge keeps dirty set so its text gets its own pass.
    dirty_d = (dirty_q && !fire) || set_dirty;
  end

  // Read address translation and column range check.
  always_comb begin
    rd_oor_d  = (rd_addr[5:0] >= 6'(LINE_WIDTH));
    ram_raddr = rd_oor_d ? 7'd0 : char_addr(rd_addr[7:6], rd_addr[4:0]);
  end

  // State registers for both FSMs, cursor and read-side flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q  <= W_CLEAR;
      trg_state_q <= T_IDLE;
      clr_idx_q   <= '0;
      line_q      <= '0;
      col_q       <= '0;
      dirty_q     <= 1'b0;
      wait_done_q <= 1'b0;
      lcd_trg_q   <= 1'b0;
      rd_oor_q    <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      trg_state_q <= trg_state_d;
      clr_idx_q   <= clr_idx_d;
      line_q      <= line_d;
      col_q       <= col_d;
      dirty_q     <= dirty_d;
      wait_done_q <= wait_done_d;
      lcd_trg_q   <= lcd_trg_d;
      rd_oor_q    <= rd_oor_d;
    end
  end

  lcd_char_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign in_ready = (wr_state_q == W_IDLE);
  assign lcd_trg  = lcd_trg_q;
  assign cur_line = line_q;
  assign cur_col  = col_q;
  assign rd_data  = rd_oor_q ? FILL_CHAR : ram_rdata;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed self-checking bench for lcd_text_buffer.
module tb_lcd_text_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data;
  logic       lcd_busy = 1'b0;
  logic       lcd_trg;
  logic [1:0] cur_line;
  logic [4:0] cur_col;

  int n_checks = 0;
  int n_fail   = 0;
  int trg_count  = 0;
  int trg_double = 0;
  logic trg_prev = 1'b0;

  lcd_text_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .lcd_busy (lcd_busy),
    .lcd_trg  (lcd_trg),
    .cur_line (cur_line),
    .cur_col  (cur_col)
  );

  always #5 clk = ~clk;

  // Count trigger pulses and flag any pulse longer than one cycle.
  always @(negedge clk) begin
    if (lcd_trg) begin
      trg_count++;
      if (trg_prev) trg_double++;
    end
    trg_prev = lcd_trg;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic send_end();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic check_cursor(input string tag, input logic [1:0] l, input logic [4:0] c);
    check({tag, "_line"}, 32'(cur_line), 32'(l));
    check({tag, "_col"},  32'(cur_col),  32'(c));
  endtask

  // Counts clock edges until in_ready rises; a clear should take exactly 80.
  task automatic wait_ready(input string tag);
    int cnt = 0;
    while (!in_ready && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check(tag, 32'(cnt), 32'd80);
  endtask

  initial begin
    logic [7:0] d;
    int snap;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_lcd_trg",  32'(lcd_trg),  32'd0);
    check("rst_rd_data",  32'(rd_data),  32'h00);
    check_cursor("rst_cursor", 2'd0, 5'd0);

    // Release and clear sweep.
    snap = trg_count;
    rst = 1'b0;
    wait_ready("clear_after_reset");
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 20; c++) begin
        rd({l[1:0], c[5:0]}, d);
        check($sformatf("clear_rd_%0d_%0d", l, c), 32'(d), 32'h20);
      end
    end
    repeat (10) @(negedge clk);
    check("clear_one_trg", 32'(trg_count - snap), 32'd1);

    // "AB" with the driver busy so both land in one pass.
    lcd_busy = 1'b1;
    snap = trg_count;
    send(8'h41);
    send(8'h42);
    send_end();
    check_cursor("ab_cursor", 2'd0, 5'd2);
    rd(8'h00, d); check("ab_rd0", 32'(d), 32'h41);
    rd(8'h01, d); check("ab_rd1", 32'(d), 32'h42);
    repeat (5) @(negedge clk);
    check("ab_no_trg_busy", 32'(trg_count - snap), 32'd0);
    lcd_busy = 1'b0;
    repeat (10) @(negedge clk);
    check("ab_one_trg", 32'(trg_count - snap), 32'd1);

    // 20 chars fill line 0, the 21st wraps to line 1.
    send(8'h0D);
    for (int i = 0; i < 20; i++) send(8'h61 + 8'(i));
    send(8'h5A);
    send_end();
    check_cursor("wrap_cursor", 2'd1, 5'd1);
    rd(8'h40, d); check("wrap_rd_40", 32'(d), 32'h5A);
    rd(8'h13, d); check("wrap_rd_13", 32'(d), 32'h74);

    // Last cell of line 3 wraps to (0,0).
    send(8'h0D);
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 19; i++) send(8'h30 + 8'(i));
    send_end();
    check_cursor("pre_last_cursor", 2'd3, 5'd19);
    send(8'h23);
    send_end();
    check_cursor("last_wrap_cursor", 2'd0, 5'd0);
    rd(8'hD3, d); check("last_rd_d3", 32'(d), 32'h23);

    // Control codes.
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h68 + 8'(i));
    send_end();
    check_cursor("ctl_start", 2'd2, 5'd5);
    send(8'h0A); send_end();
    check_cursor("ctl_lf", 2'd3, 5'd0);
    send(8'h0D); send_end();
    check_cursor("ctl_cr", 2'd3, 5'd0);
    send(8'h08); send_end();
    check_cursor("ctl_bs_sat", 2'd3, 5'd0);
    send(8'h2A);
    send(8'h08);
    send_end();
    check_cursor("ctl_bs", 2'd3, 5'd0);
    rd(8'hC0, d); check("ctl_bs_no_erase", 32'(d), 32'h2A);
    repeat (10) @(negedge clk);
    snap = trg_count;
    send(8'h01); send_end();
    check_cursor("ctl_0x01", 2'd3, 5'd0);
    repeat (10) @(negedge clk);
    check("ctl_0x01_no_trg", 32'(trg_count - snap), 32'd0);

    // Busy holds off the trigger; two writes still give one pass afterwards.
    lcd_busy = 1'b1;
    snap = trg_count;
    send(8'h58); send_end();
    repeat (10) @(negedge clk);
    check("busy_x_no_trg", 32'(trg_count - snap), 32'd0);
    send(8'h59); send_end();
    repeat (5) @(negedge clk);
    check("busy_y_no_trg", 32'(trg_count - snap), 32'd0);
    lcd_busy = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_one_trg", 32'(trg_count - snap), 32'd1);
    rd(8'hC0, d); check("busy_rd_x", 32'(d), 32'h58);
    rd(8'hC1, d); check("busy_rd_y", 32'(d), 32'h59);
    rd(8'h15, d); check("rd_col21_fill", 32'(d), 32'h20);
    rd(8'hFF, d); check("rd_col63_fill", 32'(d), 32'h20);

    // Form feed mid-stream.
    send(8'h0C);
    send_end();
    check("ff_in_ready_low", 32'(in_ready), 32'd0);
    check_cursor("ff_cursor", 2'd0, 5'd0);
    wait_ready("clear_after_ff");
    rd(8'h00, d); check("ff_rd_00", 32'(d), 32'h20);
    rd(8'hD3, d); check("ff_rd_d3", 32'(d), 32'h20);

    // Reset 40 cycles into a clear restarts the full sweep.
    send(8'h4D);
    send(8'h0C);
    send_end();
    repeat (39) @(negedge clk);
    check("rst40_in_ready_pre", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst40_in_ready", 32'(in_ready), 32'd0);
    check("rst40_lcd_trg",  32'(lcd_trg),  32'd0);
    check("rst40_rd_data",  32'(rd_data),  32'h00);
    check_cursor("rst40_cursor", 2'd0, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("clear_after_rst40");
    rd(8'h00, d); check("rst40_rd_00", 32'(d), 32'h20);

    repeat (10) @(negedge clk);
    check("no_double_trg", 32'(trg_double), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
